// File: rtl/scs8hd_rrarb_ctl_pkg.sv
// Shared arbiter definitions: FSM state encoding, clog2 helper, default hold limit.
// Pure declarations; no logic, no latency.
package scs8hd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int HOLD_MAX_DFLT = 15;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/scs8hd_rrarb_ctl_if.sv
// Request/grant bundle between requesting logic (master) and the arbiter (slave).
// Wires only; latency and backpressure are set by the arbiter.
interface scs8hd_rrarb_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   REQ;
    logic           DONE;
    logic           EN;
    logic [N-1:0]   GNT;
    logic [IDW-1:0] GNT_ID;
    logic           BUSY;
    logic           TIMEOUT;

    modport master (
        output REQ, DONE, EN,
        input  GNT, GNT_ID, BUSY, TIMEOUT
    );

    modport slave (
        input  REQ, DONE, EN,
        output GNT, GNT_ID, BUSY, TIMEOUT
    );
endinterface

// File: rtl/scs8hd_rrarb_ctl_rr_pick.sv
// Rotating priority encoder: first set req bit scanning ptr, ptr+1, ... with wrap mod N.
// Purely combinational, zero latency; vld_o low when no bit is set.
module scs8hd_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] idx_o,
    output logic           vld_o
);
    localparam logic [IDW:0] N_W = (IDW+1)'(N);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    logic           found;

    // Rotate so that bit 0 of rot is requester ptr; the first hit is then a plain LSB scan.
    assign rot = N'({req_i, req_i} >> ptr_i);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx_o = sum[IDW-1:0];
        vld_o = found;
    end

endmodule

// File: rtl/scs8hd_rrarb_ctl.sv
// Round-robin arbiter for one shared resource: IDLE -> GRANT -> GAP, one-hot registered grant.
// Latency: one cycle REQ->GNT; grant held until DONE, request drop or hold limit; one-cycle gap.
module scs8hd_rrarb_ctl
    import scs8hd_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = HOLD_MAX_DFLT,
    parameter int IDW      = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    scs8hd_rrarb_if.slave    arb
);
    localparam int CW = (clog2(HOLD_MAX + 1) < 1) ? 1 : clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(HOLD_MAX);
    localparam logic [CW-1:0]  CNT_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tmo_q, tmo_d;

    logic [IDW-1:0] pick_idx;
    logic           pick_vld;
    logic           rel_done, rel_drop, rel_tmo;

    scs8hd_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i (arb.REQ),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        rel_done = 1'b0;
        rel_drop = 1'b0;
        rel_tmo  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb.EN && pick_vld) begin
                    gnt_d   = N'(1) << pick_idx;
                    id_d    = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                rel_done = arb.DONE;
                // gnt_q is one-hot on the owner, so masking tests REQ[owner].
                rel_drop = ~|(arb.REQ & gnt_q);
                rel_tmo  = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
                if (rel_done || rel_drop || rel_tmo) begin
                    gnt_d   = '0;
                    state_d = GAP;
                    ptr_d   = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
                    tmo_d   = rel_tmo && !rel_done && !rel_drop;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign arb.GNT     = gnt_q;
    assign arb.GNT_ID  = id_q;
    assign arb.BUSY    = (state_q == GRANT);
    assign arb.TIMEOUT = tmo_q;

endmodule

// File: tb/tb_scs8hd_rrarb_ctl.sv
// Directed bench for scs8hd_rrarb_ctl (N=4, HOLD_MAX=15, IDW=2): vector table plus corner sequences.
module tb_scs8hd_rrarb_ctl;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vq[$];

    scs8hd_rrarb_if #(.N(4), .IDW(2)) bus ();

    scs8hd_rrarb_ctl #(.N(4), .HOLD_MAX(15), .IDW(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic d, input logic e,
                       input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.en = e;
        v.gnt = g; v.id = i; v.busy = b; v.tmo = t;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic d, input logic e);
        rst = r; bus.REQ = q; bus.DONE = d; bus.EN = e;
    endtask

    initial begin
        int cyc;
        int hi_tmo;
        n_cmp = 0;
        n_err = 0;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);

        //   rst  req     done  en    gnt     id  busy tmo
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);   // reset
        add(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 0, 1, 4'b0100, 2, 1, 0);   // basic grant
        add(0, 4'b0100, 1, 1, 4'b0000, 2, 0, 0);   // DONE -> GAP
        add(0, 4'b0000, 0, 1, 4'b0000, 2, 0, 0);   // IDLE, ptr=3
        add(0, 4'b1111, 0, 1, 4'b1000, 3, 1, 0);   // fairness starts at ptr=3
        add(0, 4'b1111, 1, 1, 4'b0000, 3, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 3, 0, 0);   // GAP -> IDLE, no sampling
        add(0, 4'b1111, 0, 1, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 1, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 1, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 2, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 2, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 3, 0, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 3, 0, 0);   // ptr=0
        add(0, 4'b0010, 0, 0, 4'b0000, 3, 0, 0);   // EN low blocks grant
        add(0, 4'b0010, 0, 0, 4'b0000, 3, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 3, 0, 0);
        add(0, 4'b0010, 0, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);   // EN drop keeps grant
        add(0, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 1, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 1, 0, 0);   // no new grant while EN=0
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);   // ptr=2
        add(0, 4'b0100, 0, 1, 4'b0100, 2, 1, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 2, 0, 0);   // request drop releases, no TIMEOUT
        add(0, 4'b0000, 0, 1, 4'b0000, 2, 0, 0);   // ptr=3
        add(0, 4'b1001, 0, 1, 4'b1000, 3, 1, 0);
        add(0, 4'b1001, 1, 1, 4'b0000, 3, 0, 0);
        add(0, 4'b1001, 0, 1, 4'b0000, 3, 0, 0);
        add(0, 4'b1001, 0, 1, 4'b0001, 0, 1, 0);   // wrap: 0 wins from ptr=0
        add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0, 0);   // IDLE, ptr=1

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].req, vq[i].done, vq[i].en);
            step();
            chk($sformatf("v%0d_gnt", i),  bus.GNT,     vq[i].gnt);
            chk($sformatf("v%0d_id", i),   bus.GNT_ID,  vq[i].id);
            chk($sformatf("v%0d_busy", i), bus.BUSY,    vq[i].busy);
            chk($sformatf("v%0d_tmo", i),  bus.TIMEOUT, vq[i].tmo);
        end

        // Timeout: single requester holds without DONE for exactly 15 cycles.
        drive(1'b0, 4'b0001, 1'b0, 1'b1);
        step();
        cyc = 0;
        hi_tmo = 0;
        while (bus.GNT == 4'b0001 && cyc < 40) begin
            cyc++;
            if (bus.TIMEOUT !== 1'b0 || bus.BUSY !== 1'b1) hi_tmo++;
            step();
        end
        chk("tmo_len", cyc, 15);
        chk("tmo_early", hi_tmo, 0);
        chk("tmo_pulse", bus.TIMEOUT, 1'b1);
        chk("tmo_busy", bus.BUSY, 1'b0);
        chk("tmo_gnt", bus.GNT, 4'b0000);
        bus.REQ = 4'b0000;
        step();
        chk("tmo_oneshot", bus.TIMEOUT, 1'b0);
        step();

        // DONE on the 15th GRANT cycle: DONE wins, no TIMEOUT.
        drive(1'b0, 4'b0001, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 14; k++) step();
        chk("d15_held", bus.GNT, 4'b0001);
        bus.DONE = 1'b1;
        step();
        chk("d15_gnt", bus.GNT, 4'b0000);
        chk("d15_tmo", bus.TIMEOUT, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        step();
        chk("d15_tmo2", bus.TIMEOUT, 1'b0);
        step();

        // Reset during a grant to owner 3, then ptr must restart at 0.
        drive(1'b0, 4'b1000, 1'b0, 1'b1);
        step();
        chk("rst_pre_gnt", bus.GNT, 4'b1000);
        step();
        rst = 1'b1;
        step();
        chk("rst_gnt", bus.GNT, 4'b0000);
        chk("rst_id", bus.GNT_ID, 2'd0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_tmo", bus.TIMEOUT, 1'b0);
        drive(1'b0, 4'b1001, 1'b0, 1'b1);
        step();
        chk("rst_ptr_gnt", bus.GNT, 4'b0001);
        chk("rst_ptr_id", bus.GNT_ID, 2'd0);
        bus.DONE = 1'b1;
        step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
